// File: rtl/iter_muldiv_pkg.sv
// muldiv_pkg: shared types and op-decode helpers for the iterative multiply/divide unit.
// Ports: none (package). Provides md_op_e (RV32M funct3 encoding), state_e (FSM states),
//        and decode helpers is_div / is_rem / is_mul_hi / is_signed_a / is_signed_b.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input md_op_e op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic is_mul_hi(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/iter_muldiv_addsub.sv
// addsub: W-bit adder/subtractor, sum = a + b (sub=0) or a - b (sub=1).
// Ports: a, b operands; sub mode; sum result; carry out (for subtract: 1 = no borrow);
//        overflow signed overflow; zero when sum is all zeros.
module addsub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         overflow,
    output logic         zero
);

    logic [W-1:0] b_eff;
    logic [W:0]   full;

    // Subtract as a + ~b + 1 so one adder serves both modes.
    assign b_eff    = sub ? ~b : b;
    assign full     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    assign sum      = full[W-1:0];
    assign carry    = full[W];
    assign overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
    assign zero     = (sum == '0);

endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative RV32M multiply/divide, one bit per cycle, valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, op (funct3), a, b request side;
//        out_valid/out_ready, result response side. Optional macro MULDIV_FASTPATH_EN:
//        b==0 (or a==0 for multiply) completes directly from IDLE with 1-cycle latency.
module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    md_op_e           op_in, op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q, result_q;
    logic             fix_q;
    logic             last_iter;

    assign op_in     = md_op_e'(op);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // ---------------- operand magnitudes at acceptance ----------------
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_negv, b_negv, a_abs, b_abs;
    logic             a_neg_c, a_neg_ovf, a_zero;
    logic             b_neg_c, b_neg_ovf, b_zero;
    logic             fix_d;

    assign a_neg = is_signed_a(op_in) & a[WIDTH-1];
    assign b_neg = is_signed_b(op_in) & b[WIDTH-1];

    addsub #(.W(WIDTH)) u_neg_a (
        .a('0), .b(a), .sub(1'b1),
        .sum(a_negv), .carry(a_neg_c), .overflow(a_neg_ovf), .zero(a_zero)
    );
    addsub #(.W(WIDTH)) u_neg_b (
        .a('0), .b(b), .sub(1'b1),
        .sum(b_negv), .carry(b_neg_c), .overflow(b_neg_ovf), .zero(b_zero)
    );

    assign a_abs = a_neg ? a_negv : a;
    assign b_abs = b_neg ? b_negv : b;

    // Final negate decision: product/quotient when signs differ (quotient fix
    // suppressed on divide-by-zero), remainder follows the dividend sign.
    always_comb begin
        fix_d = a_neg ^ b_neg;
        if (is_rem(op_in))      fix_d = a_neg;
        else if (is_div(op_in)) fix_d = (a_neg ^ b_neg) & ~b_zero;
    end

    // ---------------- one iteration step ----------------
    // Multiply: hi_q accumulates, lo_q holds remaining multiplier bits, opnd_q = multiplicand.
    // Divide:   hi_q is the partial remainder, lo_q shifts dividend out / quotient in,
    //           opnd_q = divisor.
    logic             div_q;
    logic [WIDTH-1:0] step_a, step_sum;
    logic             step_c, step_ovf, step_zero;
    logic             q_bit;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    assign div_q  = is_div(op_q);
    assign step_a = div_q ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : hi_q;

    addsub #(.W(WIDTH)) u_step (
        .a(step_a), .b(opnd_q), .sub(div_q),
        .sum(step_sum), .carry(step_c), .overflow(step_ovf), .zero(step_zero)
    );

    // The shifted remainder is W+1 bits wide; its dropped top bit means the
    // trial subtraction cannot go negative even if the W-bit subtract borrows.
    assign q_bit = hi_q[WIDTH-1] | step_c;

    always_comb begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        if (div_q) begin
            hi_nxt = q_bit ? step_sum : step_a;
            lo_nxt = {lo_q[WIDTH-2:0], q_bit};
        end else if (lo_q[0]) begin
            hi_nxt = {step_c, step_sum[WIDTH-1:1]};
            lo_nxt = {step_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_nxt = {1'b0, hi_q[WIDTH-1:1]};
            lo_nxt = {hi_q[0], lo_q[WIDTH-1:1]};
        end
    end

    // ---------------- final sign fix (2W-bit negate, a = 0) ----------------
    logic [2*WIDTH-1:0] fix_in, fix_neg, fin;
    logic               fix_c, fix_ovf, fix_zero;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        fix_in = {hi_nxt, lo_nxt};
        if (is_rem(op_q))      fix_in = {{WIDTH{1'b0}}, hi_nxt};
        else if (div_q)        fix_in = {{WIDTH{1'b0}}, lo_nxt};
    end

    addsub #(.W(2*WIDTH)) u_fix (
        .a('0), .b(fix_in), .sub(1'b1),
        .sum(fix_neg), .carry(fix_c), .overflow(fix_ovf), .zero(fix_zero)
    );

    assign fin     = fix_q ? fix_neg : fix_in;
    assign fin_res = is_mul_hi(op_q) ? fin[2*WIDTH-1:WIDTH] : fin[WIDTH-1:0];

    // ---------------- optional early completion ----------------
    logic             fast;
    logic [WIDTH-1:0] fast_res;
`ifdef MULDIV_FASTPATH_EN
    assign fast = b_zero | (~is_div(op_in) & a_zero);
    always_comb begin
        fast_res = '0;
        if (is_div(op_in)) fast_res = is_rem(op_in) ? a : '1;
    end
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{a_neg_c, a_neg_ovf, a_zero, b_neg_c, b_neg_ovf,
                         step_ovf, step_zero, fix_c, fix_ovf, fix_zero, fast_res};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = fast ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (last_iter) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            fix_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op_in;
                        fix_q  <= fix_d;
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        lo_q   <= is_div(op_in) ? a_abs : b_abs;
                        opnd_q <= is_div(op_in) ? b_abs : a_abs;
                        if (fast) result_q <= fast_res;
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) result_q <= fin_res;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_iter_muldiv.sv
module tb_iter_muldiv;

    localparam int W = 32;
`ifdef MULDIV_FASTPATH_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 33;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    int tests_run    = 0;
    int tests_failed = 0;

    iter_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request; lat = cycle index of first out_valid (acceptance = cycle 0).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit consume, output logic [31:0] res, output int lat,
                          output bit ir_bad);
        int guard = 0;
        ir_bad = 1'b0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(0, 7));
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        tests_run++;
        if (!out_valid) begin
            tests_failed++;
            $display("FAIL timeout op=%0d: out_valid=0 required 1", o);
        end
        res = result;
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_mul();
        logic [31:0] r; int l; bit bad;
        logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] xs  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ys  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b1, r, l, bad);
            tests_run++;
            if (r !== exp[i]) begin tests_failed++; $display("FAIL mul_result[%0d] got %h want %h", i, r, exp[i]); end
            tests_run++;
            if (l !== 33) begin tests_failed++; $display("FAIL mul_latency[%0d] got %0d want 33", i, l); end
            tests_run++;
            if (bad !== 1'b0) begin tests_failed++; $display("FAIL mul_in_ready[%0d] got high during CALC want low", i); end
        end
    endtask

    task automatic test_div();
        logic [31:0] r; int l; bit bad;
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 32'hFFFFFFF9, 32'd2, 1'b1, r, l, bad);
            tests_run++;
            if (r !== exp[i]) begin tests_failed++; $display("FAIL div_result[%0d] got %h want %h", i, r, exp[i]); end
            tests_run++;
            if (l !== 33) begin tests_failed++; $display("FAIL div_latency[%0d] got %0d want 33", i, l); end
        end
    endtask

    task automatic test_div_corner();
        logic [31:0] r; int l; bit bad;
        logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] xs  [6] = '{32'd5, 32'd5, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'h80000000, 32'h80000000};
        logic [31:0] ys  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h80000000, 32'h0};
        int          lat [6] = '{LAT_Z, LAT_Z, LAT_Z, LAT_Z, 33, 33};
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b1, r, l, bad);
            tests_run++;
            if (r !== exp[i]) begin tests_failed++; $display("FAIL corner_result[%0d] got %h want %h", i, r, exp[i]); end
            tests_run++;
            if (l !== lat[i]) begin tests_failed++; $display("FAIL corner_latency[%0d] got %0d want %0d", i, l, lat[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; int l; bit bad;
        run_op(3'b000, 32'd6, 32'd7, 1'b0, r, l, bad);
        tests_run++;
        if (r !== 32'd42) begin tests_failed++; $display("FAIL bp_result got %h want 0000002a", r); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin op = 3'b101; a = 32'd100; b = 32'd3; in_valid = 1'b1; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            tests_run++;
            if (result !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got result=%h out_valid=%b in_ready=%b want 2a/1/0", i, result, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd42) begin
            tests_failed++;
            $display("FAIL bp_pulse_ignored got in_ready=%b out_valid=%b result=%h want 1/0/2a", in_ready, out_valid, result);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int l; bit bad; bit seen = 1'b0;
        op = 3'b000; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_state got in_ready=%b out_valid=%b result=%h want 1/0/0", in_ready, out_valid, result);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL midreset_no_output got out_valid=1 want 0"); end
        run_op(3'b000, 32'd3, 32'd4, 1'b1, r, l, bad);
        tests_run++;
        if (r !== 32'd12) begin tests_failed++; $display("FAIL midreset_mul got %h want 0000000c", r); end
        tests_run++;
        if (l !== 33) begin tests_failed++; $display("FAIL midreset_latency got %0d want 33", l); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int l; bit bad;
        run_op(3'b101, 32'd100, 32'd7, 1'b1, r, l, bad);
        tests_run++;
        if (r !== 32'd14) begin tests_failed++; $display("FAIL b2b_divu got %h want 0000000e", r); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        run_op(3'b111, 32'd100, 32'd7, 1'b1, r, l, bad);
        tests_run++;
        if (r !== 32'd2) begin tests_failed++; $display("FAIL b2b_remu got %h want 00000002", r); end
        run_op(3'b011, 32'h00010000, 32'h00010000, 1'b1, r, l, bad);
        tests_run++;
        if (r !== 32'd1) begin tests_failed++; $display("FAIL b2b_mulhu got %h want 00000001", r); end
        run_op(3'b110, 32'hFFFFFF9C, 32'd7, 1'b1, r, l, bad);
        tests_run++;
        if (r !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL b2b_rem_neg got %h want fffffffe", r); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_corner();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
